// File: rtl/cpu_pkg.sv
// Shared encodings between the control unit and the execute stage:
// ALU operation codes, default datapath width and execute FSM states.
package cpu_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_LSL = 4'd7;
  localparam logic [3:0] ALU_LSR = 4'd8;
  localparam logic [3:0] ALU_LD  = 4'd9;
  localparam logic [3:0] ALU_ST  = 4'd10;
  localparam logic [3:0] ALU_MOV = 4'd11;
  localparam logic [3:0] ALU_CMP = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/iterative_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one step per clock,
// WIDTH steps per operation. done marks the edge on which q is final.
module iterative_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  // x: multiplicand (MUL) or dividend shifting into quotient (DIV)
  // y: multiplier (MUL) or divisor (DIV); acc: product or partial remainder
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    is_div_d  = is_div_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    rem_shift = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, y_q};
    if (!busy_q) begin
      if (start) begin
        x_d      = a;
        y_d      = b;
        acc_d    = '0;
        is_div_d = is_div;
        cnt_d    = CW'(WIDTH);
        busy_d   = 1'b1;
      end
    end else begin
      if (is_div_q) begin
        if (!trial[WIDTH]) begin
          acc_d = trial;
          x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_shift;
          x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = acc_q + (y_q[0] ? {1'b0, x_q} : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
    end
  end

  // q is the post-step value so the caller can register it on the done edge.
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));
  assign q    = is_div_q ? x_d : acc_d[WIDTH-1:0];

endmodule

// File: rtl/alu_exec_unit.sv
// 16-bit execute stage: single-cycle ALU ops, operand mux, flags and result
// register; MUL/DIV are delegated to the iterative_muldiv engine.
module alu_exec_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_sel,
  input  logic             imm_sel,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm_data,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             zero_flag,
  output logic             pos_flag,
  output logic             div_zero
);

  localparam int               SHW     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_U = WIDTH'(WIDTH);

  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v,
                                           input logic [WIDTH-1:0] s);
    return (s >= WIDTH_U) ? '0 : (v << s[SHW-1:0]);
  endfunction

  function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v,
                                           input logic [WIDTH-1:0] s);
    return (s >= WIDTH_U) ? '0 : (v >> s[SHW-1:0]);
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] r);
    return r == '0;
  endfunction

  function automatic logic is_pos(input logic [WIDTH-1:0] r);
    return !r[WIDTH-1] && (r != '0);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             pos_q, pos_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] b_mux;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             upd_res;
  logic             upd_flg;
  logic             is_md;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_q;

  always_comb begin
    b_mux   = imm_sel ? imm_data : rt_data;
    diff    = rs_data - b_mux;
    alu_res = '0;
    upd_res = 1'b0;
    upd_flg = 1'b0;
    case (alu_sel)
      ALU_ADD: begin alu_res = rs_data + b_mux;      upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_SUB: begin alu_res = diff;                 upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_AND: begin alu_res = rs_data & b_mux;      upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_OR:  begin alu_res = rs_data | b_mux;      upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_XOR: begin alu_res = rs_data ^ b_mux;      upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_LSL: begin alu_res = shl(rs_data, b_mux);  upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_LSR: begin alu_res = shr(rs_data, b_mux);  upd_res = 1'b1; upd_flg = 1'b1; end
      ALU_LD, ALU_ST, ALU_MOV: begin
        alu_res = b_mux;
        upd_res = 1'b1;
      end
      ALU_CMP: begin alu_res = diff;                                 upd_flg = 1'b1; end
      // Only reached on the single-cycle path when the divisor is zero.
      ALU_DIV: begin alu_res = '1;                   upd_res = 1'b1; upd_flg = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    pos_d    = pos_q;
    divz_d   = divz_q;
    md_start = 1'b0;
    is_md    = (alu_sel == ALU_MUL) || ((alu_sel == ALU_DIV) && (b_mux != '0));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_md) begin
            md_start = 1'b1;
            state_d  = ST_RUN;
          end else begin
            done_d = 1'b1;
            divz_d = (alu_sel == ALU_DIV);
            if (upd_res) result_d = alu_res;
            if (upd_flg) begin
              zero_d = is_zero(alu_res);
              pos_d  = is_pos(alu_res);
            end
          end
        end
      end
      ST_RUN: begin
        if (md_done) begin
          result_d = md_q;
          zero_d   = is_zero(md_q);
          pos_d    = is_pos(md_q);
          divz_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      pos_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      pos_q    <= pos_d;
      divz_q   <= divz_d;
    end
  end

  iterative_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (md_start),
    .is_div (alu_sel == ALU_DIV),
    .a      (rs_data),
    .b      (b_mux),
    .busy   (md_busy),
    .done   (md_done),
    .q      (md_q)
  );

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = md_busy;
  assign zero_flag = zero_q;
  assign pos_flag  = pos_q;
  assign div_zero  = divz_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import cpu_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  alu_sel;
  logic        imm_sel;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [15:0] imm_data;
  logic [15:0] result;
  logic        done;
  logic        busy;
  logic        zero_flag;
  logic        pos_flag;
  logic        div_zero;

  int total = 0;
  int bad   = 0;
  int n, bc, first, cnt;

  alu_exec_unit #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .alu_sel   (alu_sel),
    .imm_sel   (imm_sel),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .imm_data  (imm_data),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .zero_flag (zero_flag),
    .pos_flag  (pos_flag),
    .div_zero  (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one operation for a single start edge; returns at the negedge after it.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b_reg,
                       input logic [15:0] b_imm, input logic isel);
    @(negedge clock);
    alu_sel  = op;
    rs_data  = a;
    rt_data  = b_reg;
    imm_data = b_imm;
    imm_sel  = isel;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  // n = edges from the start edge until done is seen; bc = cycles busy was high.
  task automatic wait_done(output int n_o, output int bc_o);
    n_o  = 1;
    bc_o = 0;
    while (!done && n_o < 40) begin
      if (busy) bc_o++;
      @(negedge clock);
      n_o++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; alu_sel = 4'd0; imm_sel = 1'b0;
    rs_data = '0; rt_data = '0; imm_data = '0;
    #12;
    chk("rst_result", result, 16'h0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_pos", pos_flag, 0);
    chk("rst_divz", div_zero, 0);
    @(negedge clock);
    reset = 1'b1;

    issue(ALU_ADD, 16'h7FFF, 16'h0000, 16'h0001, 1'b1);
    wait_done(n, bc);
    chk("add_lat", n, 1);
    chk("add_res", result, 16'h8000);
    chk("add_zero", zero_flag, 0);
    chk("add_pos", pos_flag, 0);
    @(negedge clock);
    chk("add_pulse", done, 0);

    issue(ALU_SUB, 16'd5, 16'd5, 16'h00AA, 1'b0);
    wait_done(n, bc);
    chk("sub_res", result, 16'h0);
    chk("sub_zero", zero_flag, 1);
    chk("sub_pos", pos_flag, 0);

    issue(ALU_CMP, 16'd9, 16'd3, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("cmp_lat", n, 1);
    chk("cmp_res_kept", result, 16'h0);
    chk("cmp_zero", zero_flag, 0);
    chk("cmp_pos", pos_flag, 1);

    issue(ALU_MUL, 16'd300, 16'd300, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("mul_lat", n, 17);
    chk("mul_busy_cycles", bc, 16);
    chk("mul_res", result, 16'h5F90);
    chk("mul_pos", pos_flag, 1);
    @(negedge clock);
    chk("mul_pulse", done, 0);

    issue(ALU_DIV, 16'd100, 16'd7, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("div_lat", n, 17);
    chk("div_res", result, 16'd14);

    issue(ALU_DIV, 16'd5, 16'd0, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("div0_lat", n, 1);
    chk("div0_res", result, 16'hFFFF);
    chk("div0_flag", div_zero, 1);
    chk("div0_zero", zero_flag, 0);
    chk("div0_pos", pos_flag, 0);

    issue(ALU_ADD, 16'd1, 16'h0, 16'd2, 1'b1);
    wait_done(n, bc);
    chk("add2_res", result, 16'd3);
    chk("add2_divz_clr", div_zero, 0);

    // Second start pulse mid-DIV with different operands must be ignored.
    issue(ALU_DIV, 16'd200, 16'd9, 16'h0, 1'b0);
    first = 0;
    cnt   = 0;
    for (int c = 1; c <= 24; c++) begin
      if (done) begin
        cnt++;
        if (first == 0) first = c;
      end
      if (c == 5) begin
        start   = 1'b1;
        alu_sel = ALU_ADD;
        rs_data = 16'd1;
        rt_data = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    chk("restart_first_done", first, 17);
    chk("restart_done_count", cnt, 1);
    chk("restart_res", result, 16'd22);

    // Asynchronous reset in the middle of a MUL.
    issue(ALU_MUL, 16'd300, 16'd300, 16'h0, 1'b0);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("amid_busy", busy, 0);
    chk("amid_result", result, 16'h0);
    chk("amid_pos", pos_flag, 0);
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) cnt++;
      @(negedge clock);
    end
    chk("amid_no_done", cnt, 0);

    issue(ALU_ADD, 16'd2, 16'd3, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("post_rst_lat", n, 1);
    chk("post_rst_res", result, 16'd5);

    issue(ALU_LSL, 16'h0001, 16'h0, 16'd15, 1'b1);
    wait_done(n, bc);
    chk("lsl_res", result, 16'h8000);
    chk("lsl_pos", pos_flag, 0);

    issue(ALU_LSR, 16'h8000, 16'd16, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("lsr16_res", result, 16'h0);
    chk("lsr16_zero", zero_flag, 1);

    issue(ALU_MOV, 16'h0, 16'h0, 16'h1234, 1'b1);
    wait_done(n, bc);
    chk("mov_res", result, 16'h1234);
    chk("mov_zero_kept", zero_flag, 1);

    issue(ALU_NOP, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("nop_lat", n, 1);
    chk("nop_res_kept", result, 16'h1234);
    chk("nop_zero_kept", zero_flag, 1);

    issue(ALU_LSR, 16'hF0F0, 16'h0, 16'd4, 1'b1);
    wait_done(n, bc);
    chk("lsr4_res", result, 16'h0F0F);
    chk("lsr4_pos", pos_flag, 1);

    issue(ALU_XOR, 16'hFF00, 16'h0FF0, 16'h0, 1'b0);
    wait_done(n, bc);
    chk("xor_res", result, 16'hF0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
